fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Control-side driver of the instruction-fetch interface; produces the PC unit's program-select/reset, jump-target, jump-strobe and freeze inputs.
- Sequences one program run per start request:
  - holds the PC unit in reset with the chosen program index;
  - releases it and resolves taken branches through a jump-target lookup table;
  - freezes fetch on a halt instruction, then signals done.
- Sits between the testbench/top-level start/done handshake and the PC unit, and takes branch/halt requests from the instruction decoder.

Parameters:
- NUM_PROGS, 3, number of valid program indices (0..NUM_PROGS-1).
- PC_W, 8, width of program-counter targets.
- LUT_DEPTH, 16, number of jump-target table entries.
- LOAD_CYCLES, 2, cycles the PC unit is held in reset before a run.
- CNT_W, 16, width of the run-cycle counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to run program prog_id; sampled only in IDLE.
- prog_id  in  2  program index for the run.
- br_req  in  1  decoder: current instruction is a conditional branch.
- br_cond  in  1  branch condition flag from ALU/flags.
- br_idx  in  $clog2(LUT_DEPTH)  jump-table index from instruction.
- halt_req  in  1  decoder: current instruction is halt.
- if_reset  out  1  reset to PC unit.
- if_state  out  2  program select to PC unit.
- abs  out  PC_W  absolute jump target to PC unit.
- abs_jmp  out  1  jump strobe to PC unit.
- halt  out  1  freeze to PC unit.
- busy  out  1  run in progress (LOAD or RUN).
- done  out  1  one-cycle pulse when a run completes.
- cycle_cnt  out  CNT_W  cycles spent in RUN for the last/current run.

Behaviour:

FSM states are IDLE, LOAD, RUN, DONE.

Reset:
- FSM goes to IDLE; if_state=0; load counter=0; cycle_cnt=0.
- During reset: if_reset=1, halt=1, abs_jmp=0, abs=0, busy=0, done=0.

IDLE:
- Outputs: halt=1, if_reset=0, busy=0.
- start=1 with prog_id<NUM_PROGS: latch if_state<=prog_id, clear cycle_cnt, load counter<=0, go to LOAD.
- start with prog_id>=NUM_PROGS: ignored; stay IDLE with no output change.

LOAD:
- Outputs: if_reset=1, halt=0, busy=1.
- The load counter increments each cycle. After exactly LOAD_CYCLES cycles in LOAD, go to RUN.
- start is ignored.

RUN:
- Outputs: if_reset=0, busy=1.
- cycle_cnt increments every RUN cycle, including the halt cycle, and saturates at all-ones.
- abs_jmp = br_req & br_cond & ~halt_req. This is combinational; the PC unit samples it on the next edge.
- abs = LUT[br_idx] whenever br_req=1, otherwise 0. br_idx>=LUT_DEPTH yields 0.
- halt_req=1: halt=1 combinationally in the same cycle, so the PC freezes on the halt instruction. Next state is DONE.
- halt_req and br_req both asserted: halt wins and no jump is taken.
- start is ignored.

DONE:
- Outputs: halt=1, done=1 for exactly one cycle, busy=0, cycle_cnt held. Next state is IDLE.
- start in DONE is ignored; it must be re-asserted in IDLE.

General rules:
- cycle_cnt holds its value in IDLE until the next accepted start.
- Reset asserted in any state aborts the run and returns to IDLE next edge. No done pulse is produced.
- if_state changes only on an accepted start.
- No output is registered after the FSM state except if_state and cycle_cnt. abs, abs_jmp and halt are decoded combinationally from state and the current inputs.

Decomposition:
- Package fetch_pkg holds:
  - state enum {IDLE, LOAD, RUN, DONE};
  - PC_W and LUT_DEPTH defaults;
  - the jump-target constant array JUMP_LUT[16] of 8-bit targets.
- One sub-module, jump_lut: combinational index-to-target lookup with out-of-range returning 0. It is shared later with the assembler-facing ROM checks.

Test Plan:
- Reset 3 cycles, then idle -> if_reset=1 during reset; afterwards halt=1, busy=0, done=0, if_state=0, cycle_cnt=0.
- start=1, prog_id=1 in IDLE -> if_state=1; if_reset=1 for exactly 2 cycles; then RUN with halt=0, busy=1; cycle_cnt counts 1,2,3...
- RUN with br_req=1, br_cond=1, br_idx=5, JUMP_LUT[5]=0x2A -> same cycle abs=0x2A, abs_jmp=1. Repeat with br_cond=0 -> abs_jmp=0.
- RUN with halt_req=1 and br_req=br_cond=1 together -> halt=1, abs_jmp=0. Next cycle done=1 for one cycle, then IDLE with cycle_cnt held.
- start with prog_id=3 in IDLE, and start=1 pulsed during LOAD/RUN -> both ignored; if_state unchanged; no extra run.
- reset asserted mid-RUN after 10 cycles -> next edge IDLE, cycle_cnt=0, no done pulse; a new start with prog_id=2 then gives if_state=2 and a normal run.

Source files
------------

// File: rtl/fetch_pkg.sv
// ============================================================================
//  Module  : fetch_pkg
//  Brief   : Shared types and constants for the instruction-fetch controller.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int PC_W_DEF      = 8;
  localparam int LUT_DEPTH_DEF = 16;

  // Jump targets indexed by the branch field of the instruction word.
  localparam logic [7:0] JUMP_LUT [16] = '{
    8'h10, 8'h14, 8'h18, 8'h20, 8'h24, 8'h2A, 8'h30, 8'h38,
    8'h40, 8'h48, 8'h50, 8'h60, 8'h70, 8'h80, 8'h90, 8'hF0
  };

endpackage

`default_nettype wire

// File: rtl/fetch_ctrl_if.sv
// ============================================================================
//  Module  : fetch_ctrl_if
//  Brief   : Start/done handshake, decoder requests and PC-unit controls.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface fetch_ctrl_if #(
  parameter int PC_W      = 8,
  parameter int LUT_DEPTH = 16,
  parameter int CNT_W     = 16
);
  localparam int IDX_W = $clog2(LUT_DEPTH);

  logic             start;
  logic [1:0]       prog_id;
  logic             br_req;
  logic             br_cond;
  logic [IDX_W-1:0] br_idx;
  logic             halt_req;
  logic             if_reset;
  logic [1:0]       if_state;
  logic [PC_W-1:0]  abs;
  logic             abs_jmp;
  logic             halt;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] cycle_cnt;

  modport master (
    input  start, prog_id, br_req, br_cond, br_idx, halt_req,
    output if_reset, if_state, abs, abs_jmp, halt, busy, done, cycle_cnt
  );

  modport slave (
    output start, prog_id, br_req, br_cond, br_idx, halt_req,
    input  if_reset, if_state, abs, abs_jmp, halt, busy, done, cycle_cnt
  );

endinterface

`default_nettype wire

// File: rtl/jump_lut.sv
// ============================================================================
//  Module  : jump_lut
//  Brief   : Combinational jump-table lookup; out-of-range indices give 0.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module jump_lut
  import fetch_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int LUT_DEPTH = LUT_DEPTH_DEF,
  parameter int IDX_W     = $clog2(LUT_DEPTH)
) (
  input  wire logic [IDX_W-1:0] idx_i,
  output logic      [PC_W-1:0]  target_o
);

  always_comb begin
    target_o = '0;
    for (int i = 0; i < LUT_DEPTH && i < 16; i++) begin
      if (idx_i == IDX_W'(i)) target_o = PC_W'(JUMP_LUT[i]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
//  Module  : fetch_ctrl
//  Brief   : Sequences PC-unit reset, run, branch resolution and halt per start.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int NUM_PROGS   = 3,
  parameter int PC_W        = PC_W_DEF,
  parameter int LUT_DEPTH   = LUT_DEPTH_DEF,
  parameter int LOAD_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input wire logic    clk,
  input wire logic    reset,
  fetch_ctrl_if.master bus
);

  localparam int LD_W = (LOAD_CYCLES < 2) ? 1 : $clog2(LOAD_CYCLES);

  state_t           state_q, state_d;
  logic [1:0]       if_state_q, if_state_d;
  logic [LD_W-1:0]  load_cnt_q, load_cnt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [PC_W-1:0]  lut_target;

  jump_lut #(
    .PC_W      (PC_W),
    .LUT_DEPTH (LUT_DEPTH)
  ) u_jump_lut (
    .idx_i    (bus.br_idx),
    .target_o (lut_target)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      if_state_q  <= '0;
      load_cnt_q  <= '0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      if_state_q  <= if_state_d;
      load_cnt_q  <= load_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    if_state_d   = if_state_q;
    load_cnt_d   = load_cnt_q;
    cycle_cnt_d  = cycle_cnt_q;
    bus.if_reset = 1'b0;
    bus.halt     = 1'b1;
    bus.abs      = '0;
    bus.abs_jmp  = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start && (int'(bus.prog_id) < NUM_PROGS)) begin
          if_state_d  = bus.prog_id;
          cycle_cnt_d = '0;
          load_cnt_d  = '0;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        bus.if_reset = 1'b1;
        bus.halt     = 1'b0;
        bus.busy     = 1'b1;
        load_cnt_d   = load_cnt_q + 1'b1;
        if (load_cnt_q == LD_W'(LOAD_CYCLES - 1)) state_d = RUN;
      end
      RUN: begin
        bus.busy    = 1'b1;
        bus.halt    = bus.halt_req;
        bus.abs     = bus.br_req ? lut_target : '0;
        // Halt takes priority: the PC must freeze on the halt instruction.
        bus.abs_jmp = bus.br_req & bus.br_cond & ~bus.halt_req;
        if (cycle_cnt_q != '1) cycle_cnt_d = cycle_cnt_q + 1'b1;
        if (bus.halt_req) state_d = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset overrides the decoded outputs so the PC unit is held immediately.
    if (reset) begin
      bus.if_reset = 1'b1;
      bus.halt     = 1'b1;
      bus.abs      = '0;
      bus.abs_jmp  = 1'b0;
      bus.busy     = 1'b0;
      bus.done     = 1'b0;
    end
  end

  assign bus.if_state  = if_state_q;
  assign bus.cycle_cnt = cycle_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
//  Module  : tb_fetch_ctrl
//  Brief   : Directed scoreboard bench for the fetch controller.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_ctrl;

  logic clk;
  logic reset;

  fetch_ctrl_if #(.PC_W(8), .LUT_DEPTH(16), .CNT_W(16)) bus ();

  fetch_ctrl #(
    .NUM_PROGS   (3),
    .PC_W        (8),
    .LUT_DEPTH   (16),
    .LOAD_CYCLES (2),
    .CNT_W       (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic push(input string t, input logic [31:0] v);
    sb.push_back('{t, v});
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL sb_empty: observed %0h with no expectation queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  // Queue the expected output set for the current cycle, then sample at negedge.
  task automatic cyc(input string t, input logic ifr, input logic hlt, input logic bsy,
                     input logic dn, input logic aj, input logic [7:0] ab,
                     input logic [1:0] ifs, input logic [15:0] cc);
    push({t, ".if_reset"},  32'(ifr));
    push({t, ".halt"},      32'(hlt));
    push({t, ".busy"},      32'(bsy));
    push({t, ".done"},      32'(dn));
    push({t, ".abs_jmp"},   32'(aj));
    push({t, ".abs"},       32'(ab));
    push({t, ".if_state"},  32'(ifs));
    push({t, ".cycle_cnt"}, 32'(cc));
    @(negedge clk);
    pop_chk(32'(bus.if_reset));
    pop_chk(32'(bus.halt));
    pop_chk(32'(bus.busy));
    pop_chk(32'(bus.done));
    pop_chk(32'(bus.abs_jmp));
    pop_chk(32'(bus.abs));
    pop_chk(32'(bus.if_state));
    pop_chk(32'(bus.cycle_cnt));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.prog_id  = 2'd0;
    bus.br_req   = 1'b0;
    bus.br_cond  = 1'b0;
    bus.br_idx   = 4'd0;
    bus.halt_req = 1'b0;

    for (int i = 0; i < 3; i++) begin
      step();
      cyc("rst", 1, 1, 0, 0, 0, 8'h00, 2'd0, 16'd0);
    end
    reset = 1'b0;
    step();
    cyc("idle0", 0, 1, 0, 0, 0, 8'h00, 2'd0, 16'd0);

    // Run program 1 with branches, then halt with a simultaneous branch.
    bus.start = 1'b1; bus.prog_id = 2'd1;
    step();
    bus.prog_id = 2'd2;
    cyc("load1", 1, 0, 1, 0, 0, 8'h00, 2'd1, 16'd0);
    step();
    bus.start = 1'b0;
    cyc("load2", 1, 0, 1, 0, 0, 8'h00, 2'd1, 16'd0);
    step();
    bus.br_req = 1'b1; bus.br_cond = 1'b1; bus.br_idx = 4'd5;
    cyc("run_br_taken", 0, 0, 1, 0, 1, 8'h2A, 2'd1, 16'd0);
    step();
    bus.br_cond = 1'b0;
    cyc("run_br_not", 0, 0, 1, 0, 0, 8'h2A, 2'd1, 16'd1);
    step();
    bus.br_req = 1'b0; bus.start = 1'b1; bus.prog_id = 2'd0;
    cyc("run_nobr", 0, 0, 1, 0, 0, 8'h00, 2'd1, 16'd2);
    step();
    bus.start = 1'b0; bus.br_req = 1'b1; bus.br_cond = 1'b1; bus.br_idx = 4'd15;
    cyc("run_br15", 0, 0, 1, 0, 1, 8'hF0, 2'd1, 16'd3);
    step();
    bus.br_idx = 4'd5; bus.halt_req = 1'b1;
    cyc("run_halt_br", 0, 1, 1, 0, 0, 8'h2A, 2'd1, 16'd4);
    step();
    bus.br_req = 1'b0; bus.br_cond = 1'b0; bus.halt_req = 1'b0;
    bus.start = 1'b1; bus.prog_id = 2'd0;
    cyc("done1", 0, 1, 0, 1, 0, 8'h00, 2'd1, 16'd5);
    step();
    bus.start = 1'b0;
    cyc("idle_after1", 0, 1, 0, 0, 0, 8'h00, 2'd1, 16'd5);

    // Out-of-range program index is ignored.
    bus.start = 1'b1; bus.prog_id = 2'd3;
    step();
    bus.start = 1'b0;
    cyc("bad_prog", 0, 1, 0, 0, 0, 8'h00, 2'd1, 16'd5);
    step();
    cyc("bad_prog2", 0, 1, 0, 0, 0, 8'h00, 2'd1, 16'd5);

    // Program 2, aborted by reset after 10 RUN cycles.
    bus.start = 1'b1; bus.prog_id = 2'd2;
    step();
    bus.start = 1'b0;
    cyc("load3", 1, 0, 1, 0, 0, 8'h00, 2'd2, 16'd0);
    step();
    cyc("load4", 1, 0, 1, 0, 0, 8'h00, 2'd2, 16'd0);
    for (int k = 0; k < 10; k++) begin
      step();
      cyc("run_cnt", 0, 0, 1, 0, 0, 8'h00, 2'd2, 16'(k));
    end
    step();
    reset = 1'b1;
    cyc("mid_rst", 1, 1, 0, 0, 0, 8'h00, 2'd2, 16'd10);
    step();
    reset = 1'b0;
    cyc("after_rst", 0, 1, 0, 0, 0, 8'h00, 2'd0, 16'd0);
    step();
    cyc("no_done", 0, 1, 0, 0, 0, 8'h00, 2'd0, 16'd0);

    // Fresh run of program 2, halting on the first RUN cycle.
    bus.start = 1'b1; bus.prog_id = 2'd2;
    step();
    bus.start = 1'b0;
    cyc("load5", 1, 0, 1, 0, 0, 8'h00, 2'd2, 16'd0);
    step();
    cyc("load6", 1, 0, 1, 0, 0, 8'h00, 2'd2, 16'd0);
    step();
    bus.halt_req = 1'b1;
    cyc("run_halt", 0, 1, 1, 0, 0, 8'h00, 2'd2, 16'd0);
    step();
    bus.halt_req = 1'b0;
    cyc("done2", 0, 1, 0, 1, 0, 8'h00, 2'd2, 16'd1);
    step();
    cyc("idle_end", 0, 1, 0, 0, 0, 8'h00, 2'd2, 16'd1);

    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover: observed %0d entries expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
